// File: rtl/port_serializer_if.sv
// Parallel-in handshake plus serial-out status bundle for port_serializer.
// Zero latency (wires only); in_ready is the only backpressure signal.
// The master drives words in; the slave accepts them and drives the serial side.
interface port_serializer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ser_out;
  logic              busy;
  logic              done;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, busy, done
  );
endinterface

// File: rtl/port_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer; optional even parity via PORT_SERIALIZER_PARITY_EN.
// Latency: first bit on ser_out the cycle after acceptance; frame = (DATA_W[+1])*CLK_DIV cycles, back-to-back frames have no gap.
// Backpressure: in_ready = buffer not full; one word may wait while another shifts.
module port_serializer #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 50,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  port_serializer_if.slave  bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

`ifdef PORT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par, nxt_par;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t            state, nxt_state;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic [IW-1:0]     idx, nxt_idx;
  logic [DATA_W-1:0] sh, nxt_sh, buf_dat;
  logic              buf_full, accept, load, from_buf, frame_end, wrap;
  logic              nxt_ser, last_bit;

  assign bus.in_ready = ~buf_full;
  assign accept       = bus.in_valid & ~buf_full;
  assign wrap         = (cnt == CNT_LAST);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_sh    = sh;
    frame_end = 1'b0;
    load      = 1'b0;
    from_buf  = 1'b0;
    case (state)
      IDLE: load = accept;
      SHIFT: begin
        if (!wrap) begin
          nxt_cnt = cnt + CW'(1);
        end else if (idx != IDX_LAST) begin
          nxt_cnt = '0;
          nxt_idx = idx + IW'(1);
          nxt_sh  = (MSB_FIRST != 0) ? (sh << 1) : (sh >> 1);
        end else begin
`ifdef PORT_SERIALIZER_PARITY_EN
          nxt_cnt   = '0;
          nxt_state = PARITY;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef PORT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (!wrap) nxt_cnt = cnt + CW'(1);
        else       frame_end = 1'b1;
      end
`endif
      default: nxt_state = IDLE;
    endcase

    // Frame end: the buffered word wins over a same-edge handshake.
    if (frame_end) begin
      if (buf_full) begin
        load     = 1'b1;
        from_buf = 1'b1;
      end else if (accept) begin
        load = 1'b1;
      end else begin
        nxt_state = IDLE;
      end
    end

    if (load) begin
      nxt_state = SHIFT;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_sh    = from_buf ? buf_dat : bus.in_data;
    end
  end

`ifdef PORT_SERIALIZER_PARITY_EN
  assign nxt_par  = load ? ^nxt_sh : par;
  assign last_bit = (nxt_state == PARITY);
  assign nxt_ser  = (nxt_state == IDLE)   ? 1'b0 :
                    (nxt_state == PARITY) ? nxt_par :
                    ((MSB_FIRST != 0) ? nxt_sh[DATA_W-1] : nxt_sh[0]);
`else
  assign last_bit = (nxt_state == SHIFT) && (nxt_idx == IDX_LAST);
  assign nxt_ser  = (nxt_state == IDLE) ? 1'b0 :
                    ((MSB_FIRST != 0) ? nxt_sh[DATA_W-1] : nxt_sh[0]);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      buf_dat     <= '0;
      buf_full    <= 1'b0;
      bus.ser_out <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
`ifdef PORT_SERIALIZER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      idx   <= nxt_idx;
      sh    <= nxt_sh;
      if (from_buf) begin
        buf_full <= 1'b0;
      end else if (accept && !load) begin
        buf_full <= 1'b1;
        buf_dat  <= bus.in_data;
      end
      bus.ser_out <= nxt_ser;
      bus.busy    <= (nxt_state != IDLE);
      bus.done    <= (nxt_state != IDLE) && (nxt_cnt == CNT_LAST) && last_bit;
`ifdef PORT_SERIALIZER_PARITY_EN
      par         <= nxt_par;
`endif
    end
  end
endmodule

// File: tb/tb_port_serializer.sv
// Scoreboard bench for port_serializer: two instances (8b/div4/MSB-first and 8b/div1/LSB-first)
// checked cycle by cycle against per-frame bit sequences expanded from each accepted word.
module tb_port_serializer;
  localparam int DW = 8;
`ifdef PORT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL0 = (DW + PAR) * 4;
  localparam int FL1 = (DW + PAR) * 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  port_serializer_if #(.DATA_W(DW)) b0 ();
  port_serializer_if #(.DATA_W(DW)) b1 ();

  port_serializer #(.DATA_W(DW), .CLK_DIV(4), .MSB_FIRST(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  port_serializer #(.DATA_W(DW), .CLK_DIV(1), .MSB_FIRST(0)) u1 (.clk(clk), .rst(rst), .bus(b1));

  int n_chk  = 0;
  int n_fail = 0;
  // Each entry is one expected cycle: {done, ser_out}.
  bit [1:0] q0[$];
  bit [1:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input int ch, input logic [7:0] w);
    int div;
    int nb;
    bit msb;
    bit v;
    bit [1:0] e;
    div = (ch == 0) ? 4 : 1;
    msb = (ch == 0);
    nb  = DW + PAR;
    for (int b = 0; b < nb; b++) begin
      if (b < DW) v = msb ? w[DW-1-b] : w[b];
      else        v = ^w;
      for (int k = 0; k < div; k++) begin
        e = {(b == nb - 1) && (k == div - 1), v};
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
      end
    end
  endfunction

  task automatic mon(input int ch);
    logic so, bs, dn, rd;
    int fl, rem;
    bit have;
    bit [1:0] e;
    e = 2'b00;
    rem = 0;
    if (ch == 0) begin
      so = b0.ser_out; bs = b0.busy; dn = b0.done; rd = b0.in_ready; fl = FL0;
      have = (q0.size() > 0);
      if (have && rst) begin e = q0.pop_front(); rem = q0.size(); end
    end else begin
      so = b1.ser_out; bs = b1.busy; dn = b1.done; rd = b1.in_ready; fl = FL1;
      have = (q1.size() > 0);
      if (have && rst) begin e = q1.pop_front(); rem = q1.size(); end
    end
    if (!rst || !have) begin
      chk($sformatf("ch%0d idle ser_out", ch), so, 0);
      chk($sformatf("ch%0d idle busy", ch), bs, 0);
      chk($sformatf("ch%0d idle done", ch), dn, 0);
      chk($sformatf("ch%0d idle in_ready", ch), rd, 1);
    end else begin
      chk($sformatf("ch%0d ser_out", ch), so, e[0]);
      chk($sformatf("ch%0d done", ch), dn, e[1]);
      chk($sformatf("ch%0d busy", ch), bs, 1);
      chk($sformatf("ch%0d in_ready", ch), rd, (rem < fl) ? 1 : 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input int ch, input logic [7:0] w, input bit hold);
    bit acc;
    acc = 1'b0;
    if (ch == 0) begin b0.in_valid = 1'b1; b0.in_data = w; end
    else         begin b1.in_valid = 1'b1; b1.in_data = w; end
    for (int t = 0; t < 400 && !acc; t++) begin
      @(negedge clk);
      acc = (ch == 0) ? (b0.in_valid && b0.in_ready) : (b1.in_valid && b1.in_ready);
      @(posedge clk);
      if (acc) push_frame(ch, w);
    end
    #1;
    chk($sformatf("ch%0d handshake", ch), acc, 1);
    if (!hold) begin
      if (ch == 0) begin b0.in_valid = 1'b0; b0.in_data = 8'($urandom); end
      else         begin b1.in_valid = 1'b0; b1.in_data = 8'($urandom); end
    end
  endtask

  task automatic wait_idle(input int ch);
    int left;
    left = (ch == 0) ? q0.size() : q1.size();
    for (int t = 0; t < 3000 && left > 0; t++) begin
      @(posedge clk);
      left = (ch == 0) ? q0.size() : q1.size();
    end
    chk($sformatf("ch%0d drain", ch), left, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_traffic(input int ch, input int n);
    bit hold;
    for (int i = 0; i < n; i++) begin
      hold = (i < n - 1) && ($urandom_range(0, 2) == 0);
      send(ch, 8'($urandom), hold);
      if (!hold) begin
        repeat ($urandom_range(0, (ch == 0) ? 45 : 12)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    b0.in_valid = 1'b0; b0.in_data = '0;
    b1.in_valid = 1'b0; b1.in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word from idle, then a held-valid back-to-back pair through the buffer.
    send(0, 8'hA5, 1'b0);
    wait_idle(0);
    send(0, 8'hA5, 1'b1);
    send(0, 8'h3C, 1'b0);
    wait_idle(0);

    // One bit per cycle, LSB first.
    send(1, 8'h01, 1'b0);
    wait_idle(1);

    // Asynchronous reset in cycle 10 of a frame.
    send(0, 8'hFF, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("reset ser_out", b0.ser_out, 0);
    chk("reset busy", b0.busy, 0);
    chk("reset done", b0.done, 0);
    chk("reset in_ready", b0.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(0, 8'h80, 1'b0);
    wait_idle(0);

    // Word offered only on the last cycle of a frame loads straight into the shifter.
    send(0, 8'hA5, 1'b0);
    repeat (FL0 - 1) @(posedge clk);
    #1;
    send(0, 8'h55, 1'b0);
    wait_idle(0);

    // Parity values on the LSB-first channel.
    send(1, 8'h07, 1'b0);
    send(1, 8'hA5, 1'b0);
    wait_idle(1);

    fork
      rand_traffic(0, 25);
      rand_traffic(1, 60);
    join
    wait_idle(0);
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/port_serializer.md
PORT_SERIALIZER -- requirements
Module: port_serializer

Interface
REQ-001 Parameter DATA_W, default 8: parallel word width, in bits; SHALL be at least 1.
REQ-002 Parameter CLK_DIV, default 50: number of clk cycles each serial bit is held; SHALL be at least 1.
REQ-003 Parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_data holds a word to send.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  DATA_W  parallel word.
REQ-009 ser_out  output  1  serial bit stream, registered.
REQ-010 busy  output  1  a frame is being shifted.
REQ-011 done  output  1  one-cycle pulse marking the last cycle of a frame.

Function
REQ-012 A word SHALL transfer only on a rising edge where in_valid=1 and in_ready=1.
REQ-013 The block SHALL contain a shifter plus one holding buffer; in_ready SHALL equal NOT buffer-full, independent of in_valid.
REQ-014 FSM states SHALL be IDLE and SHIFT, plus PARITY when REQ-024 applies.
REQ-015 In IDLE with the buffer empty, an accepted word SHALL load directly into the shifter, and the FSM SHALL enter SHIFT on the same edge.
REQ-016 ser_out SHALL present the first bit from the cycle after acceptance; each bit SHALL be held exactly CLK_DIV cycles; a frame SHALL last DATA_W*CLK_DIV cycles.
REQ-017 The bit-period counter SHALL count 0 to CLK_DIV-1 and wrap; the bit index SHALL advance on the wrap; CLK_DIV=1 SHALL give one bit per cycle.
REQ-018 A word accepted during SHIFT SHALL go to the holding buffer.
REQ-019 done SHALL assert during the final cycle of the last bit of a frame (the parity bit if enabled).
REQ-020 At frame end, the next frame source SHALL be chosen in priority order; the first word SHALL follow in the next cycle with no idle gap:
- buffer full: load the buffered word and free the buffer;
- buffer empty and a handshake on that same edge: load the incoming word directly;
- otherwise: go to IDLE.
REQ-021 In IDLE, ser_out SHALL be 0 and busy SHALL be 0; busy SHALL be 1 in SHIFT and PARITY.
REQ-022 in_data SHALL be sampled only at the transfer edge; later changes SHALL NOT affect the frame.

Reset
REQ-023 While rst=0, all state SHALL clear asynchronously: FSM=IDLE, buffer empty, counters 0, ser_out=0, busy=0, done=0, in_ready=1. A frame in progress SHALL be discarded, and no done SHALL be issued for it.

Configuration
REQ-024 With PORT_SERIALIZER_PARITY_EN defined:
- each frame SHALL append a PARITY state after the data bits;
- ser_out SHALL carry the even-parity bit (XOR of the data word) for CLK_DIV cycles;
- frame length SHALL be (DATA_W+1)*CLK_DIV.
REQ-025 Without PORT_SERIALIZER_PARITY_EN, no parity logic SHALL exist, and frame length SHALL be DATA_W*CLK_DIV.

Verification
All scenarios use DATA_W=8 and CLK_DIV=4 unless stated.
REQ-026 MSB_FIRST=1, send 0xA5 from IDLE:
- ser_out = 1,0,1,0,0,1,0,1, each bit 4 cycles, starting the cycle after acceptance;
- done high on cycle 32 only;
- busy falls on cycle 33.
REQ-027 Send 0xA5, then 0x3C with in_valid held high:
- 0x3C is buffered and in_ready goes low;
- 0x3C's first bit follows 0xA5's last bit with no gap;
- in_ready returns to 1 when the buffer frees.
REQ-028 MSB_FIRST=0, CLK_DIV=1, send 0x01: ser_out = 1,0,0,0,0,0,0,0 on consecutive cycles, and done is on the 8th cycle.
REQ-029 Reset mid-frame: rst=0 on cycle 10 of 0xFF.
- Outputs are at reset values immediately.
- After release, 0x80 sends cleanly, and no done appears for 0xFF.
REQ-030 With PORT_SERIALIZER_PARITY_EN:
- 0xA5 gives a parity bit of 0;
- 0x07 gives a parity bit of 1;
- each frame is 36 cycles, with done on cycle 36.
REQ-031 Frame ends with the buffer empty while in_valid=1 on that edge with 0x55: 0x55 loads directly into the shifter, there is no idle cycle, and the buffer stays empty.
